hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised register scoreboard and stall generator for the decode stage of the MIPS pipeline, replacing the fixed one-bubble load-use check. It tracks per-register result-ready countdowns for three latency classes (ALU, load, long-latency unit) and raises a stall while a decoding instruction reads a register whose result is not yet forwardable. It also keeps the cycle and stall counters used by the debug interface. It sits between the decode stage, which supplies the source and destination fields, and the fetch and decode stall and bubble muxes, which consume `o_stall`.

## Interface
- NB_REG_ADDR, 5, register address width
- REGFILE_DEPTH, 32, number of tracked registers
- ALU_LAT, 0, stall cycles required after an ALU-class write
- LOAD_LAT, 1, stall cycles required after a load-class write
- LONG_LAT, 4, stall cycles required after a long-class (multiply/divide) write
- NB_CNT, 32, width of the performance counters
- NB_LAT, clogb2(max(ALU_LAT, LOAD_LAT, LONG_LAT)), width of each countdown (derived)

Ports:
- i_clock  in  1  single clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_valid  in  1  global step enable; when low, all state is frozen
- i_rs  in  NB_REG_ADDR  source A of the instruction in decode
- i_rt  in  NB_REG_ADDR  source B of the instruction in decode
- i_use_rs  in  1  decode instruction reads rs
- i_use_rt  in  1  decode instruction reads rt
- i_issue  in  1  decode instruction leaves decode this cycle; only honoured when o_stall=0
- i_we  in  1  issuing instruction writes a register
- i_rd  in  NB_REG_ADDR  destination of the issuing instruction
- i_class  in  2  latency class: 0 ALU, 1 load, 2 long, 3 reserved (treated as ALU)
- o_stall  out  1  hold fetch and decode, and inject a bubble into execution
- o_pending  out  REGFILE_DEPTH  bit r set when countdown[r]≠0
- o_n_clocks  out  NB_CNT  cycles elapsed with i_valid=1
- o_n_stalls  out  NB_CNT  cycles with i_valid=1 and o_stall=1

## Operation
- State: one NB_LAT-bit countdown per register, plus two counters.
- Countdown semantics: value N means a reader in decode must wait N more cycles.
- Stall, combinational: o_stall = (i_use_rs & rs≠0 & cnt[rs]≠0) | (i_use_rt & rt≠0 & cnt[rt]≠0).
- Register 0 is never marked; an issue with rd=0 is ignored.
- Per cycle with i_valid=1, evaluated in this order:
  - Every nonzero countdown decrements by 1.
  - If i_issue & i_we & ~o_stall & rd≠0, then cnt[rd] is loaded with the class latency.
  - The load overrides the decrement for the same register (newest write wins on WAW).
- The issue qualification uses the current-cycle o_stall, so a stalled instruction never marks its rd.
- A class latency of 0 leaves cnt[rd] at 0, which gives full forwarding with no stall.
- Counters:
  - o_n_clocks increments every cycle with i_valid=1.
  - o_n_stalls increments when i_valid=1 and o_stall=1.
  - Both wrap modulo 2^NB_CNT.
- i_valid=0: countdowns and counters hold. o_stall still reflects the current inputs.

## Timing
- Reset (i_reset=0) takes effect immediately and asynchronously: all countdowns 0, o_pending=0, o_n_clocks=0, o_n_stalls=0, and therefore o_stall=0.
- Reset asserted mid-stall drops o_stall in the same cycle.
- Reset is released synchronously to i_clock.
- o_pending and the counters are registered outputs, updated on the edge following the event.
- o_stall has zero cycles of latency from i_rs, i_rt, i_use_*.
- After an issue with class latency L, a dependent instruction arriving in decode on the next cycle stalls exactly L cycles.
- A dependent arriving k cycles later stalls max(L−k+1, 0)… i.e. L−(k−1) cycles, floored at 0.
- Simultaneous events:
  - Issue to rd while another register decrements: independent.
  - Reading a register in the same cycle it is issued: this is not possible, because issue and read refer to different instructions. The read sees the pre-edge countdown.

## Test plan
- Load latency: issue load, rd=5 (LOAD_LAT=1). Next cycle i_rs=5, i_use_rs=1. Required: o_stall=1 for 1 cycle, then 0; o_n_stalls=1.
- Long latency: issue long-class, rd=7 (LONG_LAT=4). Dependent arrives next cycle on rt. Required: o_stall=1 for 4 cycles, o_pending[7] clears after the 4th, o_n_stalls=4.
- Zero register and ALU class: load with rd=0, then a reader of r0. Required: no stall, o_pending=0. ALU-class write to r9 followed by a r9 reader: no stall.
- WAW: long-class rd=3 issued, then the next cycle an ALU-class rd=3. Required: cnt[3]=0 and o_pending[3]=0 after the second edge; a following r3 reader does not stall.
- Freeze: load rd=4, then hold i_valid=0 for 5 cycles with an r4 reader in decode. Required: o_stall=1 throughout, o_n_clocks and o_n_stalls unchanged. On the first i_valid=1 cycle, one stall is counted, then the reader proceeds.
- Reset mid-operation: during the long-class stall, assert i_reset=0 between edges. Required: o_stall=0 immediately, all outputs 0; after release, o_n_clocks counts from 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode-stage register scoreboard: per-register result-ready countdowns,
// load-use/long-latency stall generation and debug cycle/stall counters.
module hazard_scoreboard #(
    parameter int NB_REG_ADDR   = 5,
    parameter int REGFILE_DEPTH = 32,
    parameter int ALU_LAT       = 0,
    parameter int LOAD_LAT      = 1,
    parameter int LONG_LAT      = 4,
    parameter int NB_CNT        = 32
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic [NB_REG_ADDR-1:0]   i_rs,
    input  logic [NB_REG_ADDR-1:0]   i_rt,
    input  logic                     i_use_rs,
    input  logic                     i_use_rt,
    input  logic                     i_issue,
    input  logic                     i_we,
    input  logic [NB_REG_ADDR-1:0]   i_rd,
    input  logic [1:0]               i_class,
    output logic                     o_stall,
    output logic [REGFILE_DEPTH-1:0] o_pending,
    output logic [NB_CNT-1:0]        o_n_clocks,
    output logic [NB_CNT-1:0]        o_n_stalls
);

    // Bits needed to hold the largest latency value (at least one).
    function automatic int lat_width(input int a, input int b, input int c);
        int m;
        int w;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        w = 1;
        while ((1 << w) <= m) w++;
        return w;
    endfunction

    localparam int NB_LAT = lat_width(ALU_LAT, LOAD_LAT, LONG_LAT);

    localparam logic [NB_LAT-1:0] L_ALU  = NB_LAT'(ALU_LAT);
    localparam logic [NB_LAT-1:0] L_LOAD = NB_LAT'(LOAD_LAT);
    localparam logic [NB_LAT-1:0] L_LONG = NB_LAT'(LONG_LAT);

    logic [NB_LAT-1:0]        r_cnt [REGFILE_DEPTH];
    logic [NB_CNT-1:0]        r_n_clocks;
    logic [NB_CNT-1:0]        r_n_stalls;
    logic                     w_stall;
    logic                     w_rs_busy;
    logic                     w_rt_busy;
    logic                     w_mark;
    logic [NB_LAT-1:0]        w_lat;
    logic [REGFILE_DEPTH-1:0] w_pending;

    always_comb begin
        w_rs_busy = i_use_rs && (i_rs != '0) && (r_cnt[i_rs] != '0);
        w_rt_busy = i_use_rt && (i_rt != '0) && (r_cnt[i_rt] != '0);
        w_stall   = w_rs_busy || w_rt_busy;
    end

    // Reserved class 3 behaves as ALU.
    always_comb begin
        case (i_class)
            2'd1:    w_lat = L_LOAD;
            2'd2:    w_lat = L_LONG;
            default: w_lat = L_ALU;
        endcase
    end

    // A stalled instruction never marks its destination.
    assign w_mark = i_issue && i_we && !w_stall && (i_rd != '0);

    always_comb begin
        w_pending = '0;
        for (int r = 0; r < REGFILE_DEPTH; r++) begin
            w_pending[r] = (r_cnt[r] != '0);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int r = 0; r < REGFILE_DEPTH; r++) begin
                r_cnt[r] <= '0;
            end
            r_n_clocks <= '0;
            r_n_stalls <= '0;
        end else if (i_valid) begin
            for (int r = 0; r < REGFILE_DEPTH; r++) begin
                if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - NB_LAT'(1);
                end
            end
            // Later assignment wins: newest write overrides the decrement.
            if (w_mark) begin
                r_cnt[i_rd] <= w_lat;
            end
            r_n_clocks <= r_n_clocks + NB_CNT'(1);
            if (w_stall) begin
                r_n_stalls <= r_n_stalls + NB_CNT'(1);
            end
        end
    end

    assign o_stall    = w_stall;
    assign o_pending  = w_pending;
    assign o_n_clocks = r_n_clocks;
    assign o_n_stalls = r_n_stalls;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expectations queued with the
// stimulus, then popped and compared against the DUT outputs.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic        use_rs, use_rt, issue, we;
    logic [1:0]  cls;
    logic        stall;
    logic [31:0] pending;
    logic [31:0] n_clocks;
    logic [31:0] n_stalls;

    hazard_scoreboard dut (
        .i_clock   (clk),
        .i_reset   (rst_n),
        .i_valid   (valid),
        .i_rs      (rs),
        .i_rt      (rt),
        .i_use_rs  (use_rs),
        .i_use_rt  (use_rt),
        .i_issue   (issue),
        .i_we      (we),
        .i_rd      (rd),
        .i_class   (cls),
        .o_stall   (stall),
        .o_pending (pending),
        .o_n_clocks(n_clocks),
        .o_n_stalls(n_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   clk_m = 0;
    int   stl_m = 0;

    localparam int S_STALL = 0;
    localparam int S_PEND  = 1;
    localparam int S_CLK   = 2;
    localparam int S_STL   = 3;

    task automatic expect_(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic settle();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                S_STALL: obs = {31'd0, stall};
                S_PEND:  obs = pending;
                S_CLK:   obs = n_clocks;
                default: obs = n_stalls;
            endcase
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input bit exp_stall);
        if (valid) clk_m++;
        if (valid && exp_stall) stl_m++;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        use_rs = 1'b0;
        use_rt = 1'b0;
        issue  = 1'b0;
        we     = 1'b0;
        rs = '0; rt = '0; rd = '0; cls = '0;
    endtask

    task automatic do_issue(input logic [4:0] d, input logic [1:0] c);
        issue = 1'b1;
        we    = 1'b1;
        rd    = d;
        cls   = c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        idle();
        #12;
        expect_("rst_stall", S_STALL, 32'd0);
        expect_("rst_pend",  S_PEND,  32'd0);
        expect_("rst_clk",   S_CLK,   32'd0);
        expect_("rst_stl",   S_STL,   32'd0);
        settle();
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b1;
        tick(0);

        // Load latency
        do_issue(5'd5, 2'd1);
        expect_("ld_issue_stall", S_STALL, 32'd0);
        settle();
        tick(0);
        idle();
        rs = 5'd5; use_rs = 1'b1;
        expect_("ld_stall", S_STALL, 32'd1);
        expect_("ld_pend",  S_PEND,  32'h0000_0020);
        settle();
        tick(1);
        issue = 1'b1;
        expect_("ld_release", S_STALL, 32'd0);
        expect_("ld_pend0",   S_PEND,  32'd0);
        settle();
        tick(0);
        idle();
        expect_("ld_nstl", S_STL, 32'd1);
        expect_("ld_nclk", S_CLK, 32'(clk_m));
        settle();

        // Long latency; stalled issue must not mark r10
        do_issue(5'd7, 2'd2);
        tick(0);
        idle();
        rt = 5'd7; use_rt = 1'b1;
        do_issue(5'd10, 2'd2);
        for (int i = 0; i < 4; i++) begin
            expect_($sformatf("lng_stall%0d", i), S_STALL, 32'd1);
            expect_($sformatf("lng_pend%0d", i),  S_PEND,  32'h0000_0080);
            settle();
            tick(1);
        end
        issue = 1'b0;
        expect_("lng_release", S_STALL, 32'd0);
        expect_("lng_pend0",   S_PEND,  32'd0);
        expect_("lng_nstl",    S_STL,   32'd5);
        settle();
        tick(0);
        idle();

        // Zero register and ALU class
        do_issue(5'd0, 2'd1);
        tick(0);
        idle();
        expect_("r0_pend", S_PEND, 32'd0);
        rs = 5'd0; use_rs = 1'b1;
        do_issue(5'd9, 2'd0);
        expect_("r0_stall", S_STALL, 32'd0);
        settle();
        tick(0);
        idle();
        rs = 5'd9; use_rs = 1'b1;
        expect_("alu_stall", S_STALL, 32'd0);
        expect_("alu_pend",  S_PEND,  32'd0);
        settle();
        tick(0);
        idle();

        // WAW: ALU write overrides pending long write
        do_issue(5'd3, 2'd2);
        tick(0);
        expect_("waw_pend_long", S_PEND, 32'h0000_0008);
        settle();
        do_issue(5'd3, 2'd0);
        tick(0);
        idle();
        rt = 5'd3; use_rt = 1'b1;
        expect_("waw_pend", S_PEND,  32'd0);
        expect_("waw_stall", S_STALL, 32'd0);
        settle();
        tick(0);
        idle();

        // Freeze with i_valid low
        do_issue(5'd4, 2'd1);
        tick(0);
        idle();
        rs = 5'd4; use_rs = 1'b1;
        valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_($sformatf("frz_stall%0d", i), S_STALL, 32'd1);
            settle();
            tick(1);
        end
        expect_("frz_clk", S_CLK, 32'(clk_m));
        expect_("frz_stl", S_STL, 32'(stl_m));
        settle();
        valid = 1'b1;
        expect_("frz_stall_v", S_STALL, 32'd1);
        settle();
        tick(1);
        expect_("frz_release", S_STALL, 32'd0);
        expect_("frz_stl_v",   S_STL,   32'(stl_m));
        expect_("frz_clk_v",   S_CLK,   32'(clk_m));
        settle();
        idle();
        tick(0);

        // Asynchronous reset mid-stall
        do_issue(5'd7, 2'd2);
        tick(0);
        idle();
        rt = 5'd7; use_rt = 1'b1;
        expect_("rs_pre_stall", S_STALL, 32'd1);
        settle();
        tick(1);
        rst_n = 1'b0;
        expect_("rs_stall", S_STALL, 32'd0);
        expect_("rs_pend",  S_PEND,  32'd0);
        expect_("rs_clk",   S_CLK,   32'd0);
        expect_("rs_stl",   S_STL,   32'd0);
        settle();
        @(negedge clk);
        rst_n = 1'b1;
        clk_m = 0;
        stl_m = 0;
        expect_("rs_after_stall", S_STALL, 32'd0);
        settle();
        tick(0);
        tick(0);
        expect_("rs_clk_cnt", S_CLK, 32'd2);
        expect_("rs_stl_cnt", S_STL, 32'd0);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
